// File: rtl/rmt_pkg.sv
// Shared RMT pipeline definitions: PHV width, container field offsets and small
// elaboration-time helpers used by the match-action stages, deparser and PHV buffer.
package rmt_pkg;

  localparam int PHV_WIDTH = 1124;

  // PHV layout: 8x64b, 8x48b and 8x16b containers, then 100b of metadata.
  localparam int PHV_8B_OFF = 0;
  localparam int PHV_8B_W   = 64;
  localparam int PHV_6B_OFF = 512;
  localparam int PHV_6B_W   = 48;
  localparam int PHV_2B_OFF = 896;
  localparam int PHV_2B_W   = 16;
  localparam int PHV_MD_OFF = 1024;
  localparam int PHV_MD_W   = 100;
  localparam int PHV_N_CON  = 8;

  typedef logic [PHV_WIDTH-1:0] phv_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/rmt_phv_bank.sv
// One storage slice of the PHV buffer: registered write, combinational read.
// Contents are deliberately not reset; the owner tracks validity.
module rmt_phv_bank #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 562,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/rmt_phv_fifo.sv
// PHV buffer between the last match-action stage and the deparser: stall-free
// writes, first-word-fall-through reads, drop-on-full with a saturating counter.
module rmt_phv_fifo
  import rmt_pkg::*;
#(
  parameter int PHV_WIDTH = rmt_pkg::PHV_WIDTH,
  parameter int DEPTH     = 16,
  parameter int N_BANK    = 2,
  parameter int NF_MARGIN = 4,
  parameter int EDGE_WR   = 0,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       aresetn,
  input  logic [PHV_WIDTH-1:0]       phv_in,
  input  logic                       phv_in_valid,
  output logic [PHV_WIDTH-1:0]       phv_out,
  output logic                       phv_out_valid,
  input  logic                       phv_out_ready,
  output logic                       nearly_full,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           drop_cnt,
  input  logic                       drop_cnt_clr
);

  localparam int BANK_W   = ceil_div(PHV_WIDTH, N_BANK);
  localparam int PAD_W    = BANK_W * N_BANK;
  localparam int OCC_W    = $clog2(DEPTH + 1);
  localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NF_LEVEL = DEPTH - NF_MARGIN;

  // Read handshake: an entry leaves on any rising clk edge where phv_out_valid
  // and phv_out_ready are both high; phv_out holds steady until then. The
  // write side has no ready: a request that finds the buffer full is dropped.

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [OCC_W-1:0] occ_q, occ_next;
  logic             valid_q, wr_req, full, push, pop, drop;
  logic [PAD_W-1:0] wr_data, rd_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_data                  = '0;
    wr_data[PHV_WIDTH-1:0]   = phv_in;
  end

  assign phv_out = rd_data[PHV_WIDTH-1:0];

  assign wr_req   = (EDGE_WR != 0) ? (phv_in_valid & ~valid_q) : phv_in_valid;
  assign full     = (occ_q == OCC_W'(DEPTH));
  assign pop      = phv_out_ready & phv_out_valid;
  assign push     = wr_req & (~full | pop);
  assign drop     = wr_req & full & ~pop;
  assign occ_next = occ_q + OCC_W'(push) - OCC_W'(pop);

  assign occupancy = occ_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occ_q         <= '0;
      phv_out_valid <= 1'b0;
      nearly_full   <= (NF_LEVEL == 0);
      valid_q       <= 1'b0;
      drop_cnt      <= '0;
    end else begin
      valid_q <= phv_in_valid;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      occ_q         <= occ_next;
      phv_out_valid <= (occ_next != '0);
      nearly_full   <= (occ_next >= OCC_W'(NF_LEVEL));
      // Clear wins over the old value, but a drop in the same cycle still counts.
      if (drop_cnt_clr) begin
        drop_cnt <= drop ? CNT_W'(1) : '0;
      end else if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  // All banks share one pointer pair so the slices of a PHV stay aligned.
  for (genvar b = 0; b < N_BANK; b++) begin : g_bank
    rmt_phv_bank #(
      .DEPTH (DEPTH),
      .WIDTH (BANK_W),
      .ADDR_W(PTR_W)
    ) u_bank (
      .clk    (clk),
      .wr_en  (push),
      .wr_addr(wr_ptr),
      .wr_data(wr_data[b*BANK_W +: BANK_W]),
      .rd_addr(rd_ptr),
      .rd_data(rd_data[b*BANK_W +: BANK_W])
    );
  end

endmodule

// File: tb/tb_rmt_phv_fifo.sv
// Bench for rmt_phv_fifo: three configurations (level write, edge write, DEPTH=5
// with padded banks) checked against a queue-based model plus directed checks.
module tb_rmt_phv_fifo;

  localparam int PHV_W = rmt_pkg::PHV_WIDTH;
  typedef logic [PHV_W-1:0] phv_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT wiring ----------------
  logic [2:0] in_valid = '0;
  logic [2:0] ready    = '0;
  logic [2:0] clr      = '0;
  phv_t       din [3];

  phv_t        dout_a, dout_b, dout_c;
  logic        ov_a, ov_b, ov_c, nf_a, nf_b, nf_c;
  logic [4:0]  occ_a, occ_b;
  logic [2:0]  occ_c;
  logic [3:0]  drop_a;
  logic [15:0] drop_b, drop_c;

  rmt_phv_fifo #(.DEPTH(16), .N_BANK(2), .NF_MARGIN(4), .EDGE_WR(0), .CNT_W(4)) u_dut_a (
    .clk(clk), .aresetn(rst_n), .phv_in(din[0]), .phv_in_valid(in_valid[0]),
    .phv_out(dout_a), .phv_out_valid(ov_a), .phv_out_ready(ready[0]),
    .nearly_full(nf_a), .occupancy(occ_a), .drop_cnt(drop_a), .drop_cnt_clr(clr[0]));

  rmt_phv_fifo #(.DEPTH(16), .N_BANK(2), .NF_MARGIN(4), .EDGE_WR(1), .CNT_W(16)) u_dut_b (
    .clk(clk), .aresetn(rst_n), .phv_in(din[1]), .phv_in_valid(in_valid[1]),
    .phv_out(dout_b), .phv_out_valid(ov_b), .phv_out_ready(ready[1]),
    .nearly_full(nf_b), .occupancy(occ_b), .drop_cnt(drop_b), .drop_cnt_clr(clr[1]));

  rmt_phv_fifo #(.DEPTH(5), .N_BANK(3), .NF_MARGIN(1), .EDGE_WR(0), .CNT_W(16)) u_dut_c (
    .clk(clk), .aresetn(rst_n), .phv_in(din[2]), .phv_in_valid(in_valid[2]),
    .phv_out(dout_c), .phv_out_valid(ov_c), .phv_out_ready(ready[2]),
    .nearly_full(nf_c), .occupancy(occ_c), .drop_cnt(drop_c), .drop_cnt_clr(clr[2]));

  phv_t obs_dout [3];
  int   obs_valid [3], obs_nf [3], obs_occ [3], obs_drop [3];

  always_comb begin
    obs_dout[0] = dout_a;     obs_dout[1] = dout_b;     obs_dout[2] = dout_c;
    obs_valid[0] = int'(ov_a); obs_valid[1] = int'(ov_b); obs_valid[2] = int'(ov_c);
    obs_nf[0] = int'(nf_a);   obs_nf[1] = int'(nf_b);   obs_nf[2] = int'(nf_c);
    obs_occ[0] = int'(occ_a); obs_occ[1] = int'(occ_b); obs_occ[2] = int'(occ_c);
    obs_drop[0] = int'(drop_a); obs_drop[1] = int'(drop_b); obs_drop[2] = int'(drop_c);
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input phv_t got, input phv_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (low 64 bits shown)", tag, got[63:0], exp[63:0]);
    end
  endtask

  // ---------------- reference model ----------------
  int   m_depth [3] = '{16, 16, 5};
  int   m_edge  [3] = '{0, 1, 0};
  int   m_max   [3] = '{15, 65535, 65535};
  int   m_level [3] = '{12, 12, 4};
  phv_t exp_q   [3][$];
  int   m_cnt   [3] = '{0, 0, 0};
  bit   m_prev  [3] = '{1'b0, 1'b0, 1'b0};

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < 3; i++) begin
        if (!rst_n) begin
          exp_q[i].delete();
          m_cnt[i]  = 0;
          m_prev[i] = 1'b0;
        end else begin
          bit req, take, dropped;
          req       = in_valid[i] && !((m_edge[i] != 0) && m_prev[i]);
          m_prev[i] = in_valid[i];
          take      = ready[i] && (exp_q[i].size() > 0);
          if (take) void'(exp_q[i].pop_front());
          dropped = 1'b0;
          if (req) begin
            if (exp_q[i].size() < m_depth[i]) exp_q[i].push_back(din[i]);
            else dropped = 1'b1;
          end
          if (clr[i]) m_cnt[i] = 0;
          if (dropped && (m_cnt[i] < m_max[i])) m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
  end

  // Scoreboard: every falling edge out of reset, all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int i = 0; i < 3; i++) begin
          check($sformatf("sb_valid%0d", i), phv_t'(obs_valid[i]), phv_t'(exp_q[i].size() > 0));
          check($sformatf("sb_occ%0d", i), phv_t'(obs_occ[i]), phv_t'(exp_q[i].size()));
          check($sformatf("sb_nf%0d", i), phv_t'(obs_nf[i]), phv_t'(exp_q[i].size() >= m_level[i]));
          check($sformatf("sb_drop%0d", i), phv_t'(obs_drop[i]), phv_t'(m_cnt[i]));
          if (exp_q[i].size() > 0) check($sformatf("sb_head%0d", i), obs_dout[i], exp_q[i][0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic phv_t mk(input int k);
    logic [31:0] kk;
    phv_t        r;
    kk = k;
    for (int i = 0; i < PHV_W; i++) r[i] = kk[i % 32];
    return r;
  endfunction

  function automatic phv_t rand_phv();
    phv_t r;
    r = '0;
    for (int j = 0; j < (PHV_W + 31) / 32; j++) r = (r << 32) | phv_t'($urandom());
    return r;
  endfunction

  task automatic step(input logic [2:0] v, input logic [2:0] r, input logic [2:0] c, input phv_t d);
    @(negedge clk);
    #1;
    in_valid = v;
    ready    = r;
    clr      = c;
    for (int i = 0; i < 3; i++) din[i] = d;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 3; i++) din[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", phv_t'(obs_valid[0]), phv_t'(0));
    check("rst_occ",   phv_t'(obs_occ[0]),   phv_t'(0));
    check("rst_nf",    phv_t'(obs_nf[0]),    phv_t'(0));
    check("rst_drop",  phv_t'(obs_drop[0]),  phv_t'(0));
    check("rst_occ_c", phv_t'(obs_occ[2]),   phv_t'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // single PHV, one valid cycle
    step(3'b111, 3'b000, 3'b000, mk(32'hA5)); settle();
    check("one_valid", phv_t'(obs_valid[0]), phv_t'(1));
    check("one_data",  obs_dout[0], mk(32'hA5));
    check("one_occ",   phv_t'(obs_occ[0]), phv_t'(1));
    check("one_occ_b", phv_t'(obs_occ[1]), phv_t'(1));
    check("one_data_c", obs_dout[2], mk(32'hA5));
    step(3'b000, 3'b111, 3'b000, '0); settle();
    check("pop_occ",   phv_t'(obs_occ[0]),   phv_t'(0));
    check("pop_valid", phv_t'(obs_valid[0]), phv_t'(0));

    // fill to nearly-full, full, then drops
    for (int k = 0; k < 11; k++) begin step(3'b001, 3'b000, 3'b000, mk(k)); settle(); end
    check("nf_below", phv_t'(obs_nf[0]), phv_t'(0));
    step(3'b001, 3'b000, 3'b000, mk(11)); settle();
    check("nf_rise", phv_t'(obs_nf[0]), phv_t'(1));
    check("nf_occ",  phv_t'(obs_occ[0]), phv_t'(12));
    for (int k = 12; k < 16; k++) begin step(3'b001, 3'b000, 3'b000, mk(k)); settle(); end
    check("full_occ", phv_t'(obs_occ[0]), phv_t'(16));
    for (int k = 0; k < 3; k++) begin step(3'b001, 3'b000, 3'b000, mk(100 + k)); settle(); end
    check("drop3_cnt", phv_t'(obs_drop[0]), phv_t'(3));
    check("drop3_occ", phv_t'(obs_occ[0]),  phv_t'(16));
    for (int k = 0; k < 16; k++) begin
      check("drain_order", obs_dout[0], mk(k));
      step(3'b000, 3'b001, 3'b000, '0); settle();
    end
    check("drain_empty", phv_t'(obs_valid[0]), phv_t'(0));

    // full with simultaneous push and pop
    for (int k = 0; k < 16; k++) begin step(3'b001, 3'b000, 3'b000, mk(200 + k)); settle(); end
    step(3'b001, 3'b001, 3'b000, mk(999)); settle();
    check("simul_occ",  phv_t'(obs_occ[0]),  phv_t'(16));
    check("simul_drop", phv_t'(obs_drop[0]), phv_t'(3));
    for (int k = 1; k < 16; k++) begin
      check("simul_order", obs_dout[0], mk(200 + k));
      step(3'b000, 3'b001, 3'b000, '0); settle();
    end
    check("simul_last", obs_dout[0], mk(999));
    step(3'b000, 3'b001, 3'b000, '0); settle();

    // saturation of the 4-bit counter, then clear together with a drop
    step(3'b000, 3'b000, 3'b001, '0); settle();
    check("clr_zero", phv_t'(obs_drop[0]), phv_t'(0));
    for (int k = 0; k < 16; k++) begin step(3'b001, 3'b000, 3'b000, mk(k)); settle(); end
    for (int k = 0; k < 20; k++) begin step(3'b001, 3'b000, 3'b000, mk(50)); settle(); end
    check("sat_cnt", phv_t'(obs_drop[0]), phv_t'(15));
    step(3'b001, 3'b000, 3'b001, mk(7)); settle();
    check("clr_drop", phv_t'(obs_drop[0]), phv_t'(1));
    for (int k = 0; k < 16; k++) begin step(3'b000, 3'b001, 3'b000, '0); settle(); end

    // edge versus level write mode, valid held for 5 cycles
    for (int k = 0; k < 5; k++) begin step(3'b011, 3'b000, 3'b000, mk(5)); settle(); end
    step(3'b000, 3'b000, 3'b000, '0); settle();
    check("edge_occ",  phv_t'(obs_occ[1]), phv_t'(1));
    check("level_occ", phv_t'(obs_occ[0]), phv_t'(5));
    for (int k = 0; k < 5; k++) begin step(3'b000, 3'b011, 3'b000, '0); settle(); end

    // asynchronous reset in the middle of a burst
    for (int k = 0; k < 7; k++) begin step(3'b001, 3'b000, 3'b000, mk(300 + k)); settle(); end
    check("burst_occ", phv_t'(obs_occ[0]), phv_t'(7));
    #1;
    rst_n    = 1'b0;
    in_valid = '0;
    #1;
    check("arst_occ",   phv_t'(obs_occ[0]),   phv_t'(0));
    check("arst_valid", phv_t'(obs_valid[0]), phv_t'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step(3'b001, 3'b000, 3'b000, mk(42)); settle();
    check("post_rst_data", obs_dout[0], mk(42));
    check("post_rst_occ",  phv_t'(obs_occ[0]), phv_t'(1));
    step(3'b000, 3'b001, 3'b000, '0); settle();

    // DEPTH=5 wrap: 12 writes and 12 reads
    step(3'b100, 3'b000, 3'b000, mk(500)); settle();
    for (int k = 1; k < 12; k++) begin
      check("wrap_head", obs_dout[2], mk(500 + k - 1));
      step(3'b100, 3'b100, 3'b000, mk(500 + k)); settle();
    end
    check("wrap_last", obs_dout[2], mk(511));
    step(3'b000, 3'b100, 3'b000, '0); settle();
    check("wrap_empty", phv_t'(obs_occ[2]), phv_t'(0));

    // randomized traffic, write-heavy then read-heavy
    for (int c = 0; c < 800; c++) begin
      logic [2:0] v, r, cl;
      for (int i = 0; i < 3; i++) begin
        v[i]  = ($urandom_range(0, 9) < ((c < 400) ? 7 : 3));
        r[i]  = ($urandom_range(0, 9) < ((c < 400) ? 4 : 7));
        cl[i] = ($urandom_range(0, 63) == 0);
      end
      step(v, r, cl, rand_phv());
    end
    step(3'b000, 3'b000, 3'b000, '0);
    settle();
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
